// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt core among N_REQ stb/ack requesters.
// One operation in flight; every output is driven straight from a register.
module sqrt_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0]       req_a_stb,
  output logic [N_REQ-1:0]       req_a_ack,
  output logic [WIDTH-1:0]       resp_z,
  output logic [N_REQ-1:0]       resp_z_stb,
  input  logic [N_REQ-1:0]       resp_z_ack,
  output logic [WIDTH-1:0]       core_a,
  output logic                   core_a_stb,
  input  logic                   core_a_ack,
  input  logic [WIDTH-1:0]       core_z,
  input  logic                   core_z_stb,
  output logic                   core_z_ack,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy
);

  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t            state, state_d;
  logic [ID_W-1:0]   last_grant, last_grant_d;
  logic [ID_W-1:0]   grant_id_d;
  logic [N_REQ-1:0]  req_a_ack_d;
  logic [WIDTH-1:0]  resp_z_d;
  logic [N_REQ-1:0]  resp_z_stb_d;
  logic [WIDTH-1:0]  core_a_d;
  logic              core_a_stb_d;
  logic              core_z_ack_d;
  logic              busy_d;

  logic              found;
  logic [ID_W-1:0]   pick;
  logic [WIDTH-1:0]  pick_a;
  int unsigned       idx;

  // Rotating priority scan starting just after the last served requester.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    pick_a = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = (32'(last_grant) + k) % NR;
      if (!found && |(req_a_stb & (N_REQ'(1) << idx))) begin
        found  = 1'b1;
        pick   = ID_W'(idx);
        pick_a = WIDTH'(req_a >> (idx * 32'(WIDTH)));
      end
    end
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    grant_id_d   = grant_id;
    req_a_ack_d  = '0;
    resp_z_d     = resp_z;
    resp_z_stb_d = resp_z_stb;
    core_a_d     = core_a;
    core_a_stb_d = core_a_stb;
    core_z_ack_d = core_z_ack;

    case (state)
      IDLE: begin
        if (found) begin
          core_a_d     = pick_a;
          grant_id_d   = pick;
          req_a_ack_d  = N_REQ'(1) << pick;
          core_a_stb_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (core_a_ack) begin
          core_a_stb_d = 1'b0;
          core_z_ack_d = 1'b1;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (core_z_stb) begin
          resp_z_d     = core_z;
          core_z_ack_d = 1'b0;
          resp_z_stb_d = N_REQ'(1) << grant_id;
          state_d      = DELIVER;
        end
      end
      DELIVER: begin
        // resp_z_stb is one-hot on grant_id, so other requesters' acks are masked.
        if (|(resp_z_stb & resp_z_ack)) begin
          resp_z_stb_d = '0;
          last_grant_d = grant_id;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      grant_id   <= '0;
      req_a_ack  <= '0;
      resp_z     <= '0;
      resp_z_stb <= '0;
      core_a     <= '0;
      core_a_stb <= 1'b0;
      core_z_ack <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      grant_id   <= grant_id_d;
      req_a_ack  <= req_a_ack_d;
      resp_z     <= resp_z_d;
      resp_z_stb <= resp_z_stb_d;
      core_a     <= core_a_d;
      core_a_stb <= core_a_stb_d;
      core_z_ack <= core_z_ack_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: transaction-level round-robin model, behavioural sqrt core,
// random requesters/consumers, plus directed scenarios.
module tb_sqrt_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*W-1:0] req_a = '0;
  logic [N-1:0]   req_a_stb = '0;
  logic [N-1:0]   req_a_ack;
  logic [W-1:0]   resp_z;
  logic [N-1:0]   resp_z_stb;
  logic [N-1:0]   resp_z_ack = '0;
  logic [W-1:0]   core_a;
  logic           core_a_stb;
  logic           core_a_ack = 1'b0;
  logic [W-1:0]   core_z = '0;
  logic           core_z_stb = 1'b0;
  logic           core_z_ack;
  logic [IDW-1:0] grant_id;
  logic           busy;

  sqrt_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_a_stb(req_a_stb), .req_a_ack(req_a_ack),
    .resp_z(resp_z), .resp_z_stb(resp_z_stb), .resp_z_ack(resp_z_ack),
    .core_a(core_a), .core_a_stb(core_a_stb), .core_a_ack(core_a_ack),
    .core_z(core_z), .core_z_stb(core_z_stb), .core_z_ack(core_z_ack),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_tot = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact float encoding of a small positive integer.
  function automatic logic [31:0] i2f(input int unsigned v);
    int unsigned p = 0;
    if (v == 0) return 32'h0;
    for (int unsigned b = 0; b < 24; b++) if (v[b]) p = b;
    return {1'b0, 8'(127 + p), 23'((v << (23 - p)) & 32'h7FFFFF)};
  endfunction

  function automatic int unsigned f2i(input logic [31:0] b);
    int e = int'(b[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    return 32'({1'b1, b[22:0]}) >> (23 - e);
  endfunction

  function automatic int unsigned isqrt(input int unsigned v);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int rr(input logic [N-1:0] s, input int last);
    for (int k = 1; k <= N; k++) begin
      int i = (last + k) % N;
      if (s[i]) return i;
    end
    return -1;
  endfunction

  // Reference model: phase 0 idle, 1 operand offered, 2 awaiting core, 3 result offered.
  int          m_stage = 0;
  int          m_last = N - 1;
  int          m_grant = 0;
  int          m_root = 0;
  int          m_done = 0;
  logic [31:0] m_core_a = '0;
  logic [31:0] m_resp = '0;
  int          m_n[N];
  int          glog[$];

  // Agent knobs and sqrt core state.
  int          core_ack_pct = 100, core_hold = 0, core_lat_min = 0, core_lat_max = 3;
  int          resp_pct = 100, resp_hold = 0, raise_pct = 0, wd_pct = 0, spur = 0;
  bit          core_has = 1'b0;
  int          core_cnt = 0;
  logic [31:0] core_res = '0;

  task automatic raise(input int i, input int n);
    m_n[i] = n;
    req_a[i*W +: W] = i2f(n * n);
    req_a_stb[i] = 1'b1;
  endtask

  task automatic cycle();
    logic [N-1:0] exp_ack;
    int g;
    bit issued;
    @(negedge clk);
    exp_ack = '0;
    issued = 1'b0;
    if (!rst) begin
      m_stage = 0; m_last = N - 1; m_grant = 0; m_core_a = '0; m_resp = '0;
      core_has = 1'b0;
      chk("rst_req_a_ack", req_a_ack, 0);
      chk("rst_resp_z_stb", resp_z_stb, 0);
      chk("rst_core_a_stb", core_a_stb, 0);
      chk("rst_core_z_ack", core_z_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
    end else begin
      case (m_stage)
        0: if (req_a_stb != '0) begin
             g = rr(req_a_stb, m_last);
             exp_ack[g] = 1'b1;
             m_grant = g; m_root = m_n[g];
             m_core_a = i2f(m_root * m_root);
             m_stage = 1;
             glog.push_back(g);
           end
        1: if (core_a_ack) begin m_stage = 2; issued = 1'b1; end
        2: if (core_z_stb) begin m_stage = 3; m_resp = i2f(m_root); core_has = 1'b0; end
        3: if (resp_z_ack[m_grant]) begin m_stage = 0; m_last = m_grant; m_done++; end
        default: m_stage = 0;
      endcase
      chk("req_a_ack", req_a_ack, exp_ack);
      chk("grant_id", grant_id, m_grant);
      chk("core_a", core_a, m_core_a);
      chk("core_a_stb", core_a_stb, m_stage == 1);
      chk("core_z_ack", core_z_ack, m_stage == 2);
      chk("resp_z_stb", resp_z_stb, (m_stage == 3) ? (32'd1 << m_grant) : 32'd0);
      chk("resp_z", resp_z, m_resp);
      chk("busy", busy, m_stage != 0);
    end
    if (issued) begin
      core_has = 1'b1;
      core_res = i2f(isqrt(f2i(core_a)));
      core_cnt = $urandom_range(core_lat_max, core_lat_min);
    end
    for (int i = 0; i < N; i++) begin
      if (req_a_ack[i]) req_a_stb[i] = 1'b0;
      else if (req_a_stb[i] && $urandom_range(99) < wd_pct) req_a_stb[i] = 1'b0;
      else if (!req_a_stb[i] && $urandom_range(99) < raise_pct) raise(i, $urandom_range(64, 1));
    end
    if (core_hold > 0) begin core_a_ack = 1'b0; core_hold--; end
    else core_a_ack = !core_has && ($urandom_range(99) < core_ack_pct);
    if (core_has) begin
      if (core_cnt > 0) begin core_cnt--; core_z_stb = 1'b0; core_z = $urandom; end
      else begin core_z_stb = 1'b1; core_z = core_res; end
    end else if (spur > 0) begin
      core_z_stb = 1'b1; core_z = $urandom; spur--;
    end else core_z_stb = 1'b0;
    if (resp_hold > 0) begin resp_z_ack = '0; resp_hold--; end
    else for (int i = 0; i < N; i++) resp_z_ack[i] = ($urandom_range(99) < resp_pct);
  endtask

  task automatic run_done(input int target, input int max);
    int c = 0;
    while (m_done < target && c < max) begin cycle(); c++; end
    chk("done_bound", m_done >= target, 1);
  endtask

  task automatic run_stage(input int s, input int max);
    int c = 0;
    while (m_stage != s && c < max) begin cycle(); c++; end
    chk("stage_bound", m_stage == s, 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_n[i] = 0;
    repeat (3) cycle();
    rst = 1'b1;

    // Single request from requester 2: 25.0 -> 5.0
    resp_z_ack = '0; resp_hold = 5;
    raise(2, 5);
    cycle();
    chk("t1_ack", req_a_ack, 32'h4);
    chk("t1_grant", grant_id, 2);
    chk("t1_core_a", core_a, 32'h41C80000);
    chk("t1_core_a_stb", core_a_stb, 1);
    cycle();
    chk("t1_ack_pulse", req_a_ack, 0);
    run_stage(3, 50);
    chk("t1_resp_z", resp_z, 32'h40A00000);
    chk("t1_resp_stb", resp_z_stb, 32'h4);
    run_done(1, 50);
    chk("t1_resp_hold", resp_z, 32'h40A00000);

    // Simultaneous requests after reset: fixed order 0..3
    reset_pulse();
    glog.delete();
    raise(0, 4); raise(1, 3); raise(2, 2); raise(3, 1);
    run_done(m_done + 4, 200);
    chk("t2_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("t2_order", glog[i], i);
    chk("t2_last_resp", resp_z, 32'h3F800000);

    // Round-robin wrap: after serving 1, 3 beats 0
    raise(1, 7);
    run_done(m_done + 1, 100);
    glog.delete();
    raise(0, 8); raise(3, 9);
    run_done(m_done + 2, 200);
    chk("t3_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t3_first", glog[0], 3);
      chk("t3_second", glog[1], 0);
    end

    // Core backpressure on the operand handshake
    core_a_ack = 1'b0; core_hold = 6;
    raise(2, 10);
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_core_a_stb", core_a_stb, 1);
      chk("t4_core_a", core_a, i2f(100));
      chk("t4_core_z_ack", core_z_ack, 0);
      chk("t4_busy", busy, 1);
    end
    run_done(m_done + 1, 100);

    // Result backpressure with other requesters waiting
    raise(0, 11);
    run_stage(3, 100);
    resp_z_ack = '0; resp_hold = 10;
    raise(1, 12); raise(2, 13);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t5_req_a_ack", req_a_ack, 0);
      chk("t5_core_z_ack", core_z_ack, 0);
      chk("t5_resp_z", resp_z, i2f(11));
      chk("t5_resp_stb", resp_z_stb, 32'h1);
    end
    run_done(m_done + 3, 300);

    // Spurious core result while idle
    spur = 3;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t6_core_z_ack", core_z_ack, 0);
      chk("t6_busy", busy, 0);
    end

    // Reset while waiting for the core
    core_lat_min = 20; core_lat_max = 25;
    raise(1, 14);
    run_stage(2, 50);
    cycle();
    rst = 1'b0;
    #1;
    chk("t7_req_a_ack", req_a_ack, 0);
    chk("t7_resp_z", resp_z, 0);
    chk("t7_resp_stb", resp_z_stb, 0);
    chk("t7_core_a", core_a, 0);
    chk("t7_core_a_stb", core_a_stb, 0);
    chk("t7_core_z_ack", core_z_ack, 0);
    chk("t7_grant_id", grant_id, 0);
    chk("t7_busy", busy, 0);
    req_a_stb = '0;
    raise(3, 15); raise(0, 16);
    core_lat_min = 0; core_lat_max = 3;
    repeat (2) cycle();
    rst = 1'b1;
    glog.delete();
    run_done(m_done + 2, 200);
    chk("t7_count", glog.size(), 2);
    if (glog.size() > 0) chk("t7_first", glog[0], 0);

    // Random traffic with withdrawals and random backpressure
    begin
      int start = m_done;
      raise_pct = 30; wd_pct = 3; core_ack_pct = 50; core_lat_max = 4; resp_pct = 50;
      repeat (3000) cycle();
      raise_pct = 0; wd_pct = 0;
      begin
        int c = 0;
        while ((m_stage != 0 || req_a_stb != '0) && c < 1000) begin cycle(); c++; end
      end
      repeat (3) cycle();
      chk("rand_drained", busy, 0);
      chk("rand_progress", (m_done - start) > 50, 1);
    end

    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end

endmodule
